// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the program-memory arbiter slice.
// The optional loader path is enabled with the PROG_MEM_LOADER_EN macro.
package prog_mem_pkg;

    localparam int PM_AW = 14;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_IF   = 2'd1,
        TAG_LPM  = 2'd2
    } tag_e;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

endpackage

// File: rtl/prog_mem_if.sv
// Bundle of requester, loader and memory signals around the program-memory arbiter.
// The loader signals only take effect when PROG_MEM_LOADER_EN is defined.
interface prog_mem_if #(parameter int AW = prog_mem_pkg::PM_AW);

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_valid;
    logic [15:0]   if_data;

    logic          lpm_req;
    logic [AW:0]   lpm_addr;
    logic          lpm_gnt;
    logic          lpm_valid;
    logic [7:0]    lpm_data;

    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [15:0]   ld_data;
    logic          cpu_hold;
    logic [AW:0]   ld_count;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_din;
    logic [15:0]   mem_dout;

    modport slave (
        input  if_req, if_addr, lpm_req, lpm_addr, ld_valid, ld_addr, ld_data, mem_dout,
        output if_gnt, if_valid, if_data, lpm_gnt, lpm_valid, lpm_data,
               ld_ready, cpu_hold, ld_count, mem_we, mem_addr, mem_din
    );

    modport master (
        output if_req, if_addr, lpm_req, lpm_addr, ld_valid, ld_addr, ld_data, mem_dout,
        input  if_gnt, if_valid, if_data, lpm_gnt, lpm_valid, lpm_data,
               ld_ready, cpu_hold, ld_count, mem_we, mem_addr, mem_din
    );

endinterface

// File: rtl/prog_mem_grant.sv
// Combinational one-hot read picker: loader blocks reads, LPM beats fetch,
// except directly after an LPM grant when a waiting fetch gets its turn.
module prog_mem_grant
    import prog_mem_pkg::*;
(
    input  logic en,
    input  logic ld_take,
    input  logic lpm_req,
    input  logic if_req,
    input  logic starve,
    output tag_e tag
);

    always_comb begin
        tag = TAG_NONE;
        if (en && !ld_take) begin
            if (lpm_req && !(starve && if_req)) begin
                tag = TAG_LPM;
            end else if (if_req) begin
                tag = TAG_IF;
            end
        end
    end

endmodule

// File: rtl/prog_mem_arbiter.sv
// Program-memory arbiter: fetch/LPM reads share one registered memory port,
// and an optional loader (PROG_MEM_LOADER_EN) can take the port over to write.
module prog_mem_arbiter
    import prog_mem_pkg::*;
#(
    parameter int AW = PM_AW
) (
    input logic       clk,
    input logic       rst,
    prog_mem_if.slave bus
);

    localparam logic [1:0] RUN = ST_RUN;
`ifdef PROG_MEM_LOADER_EN
    localparam logic [1:0] LOAD    = ST_LOAD;
    localparam logic [1:0] DRAIN   = ST_DRAIN;
    localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};
`endif

    logic [1:0]    state_q, state_d;
    logic [AW:0]   ld_count_q, ld_count_d;
    logic          starve_q, starve_d;
    tag_e          pend_q, pend_d;
    logic          lpm_lane_q, lpm_lane_d;
    logic [15:0]   if_data_q, if_data_d;
    logic [7:0]    lpm_data_q, lpm_data_d;

    logic          grant_en;
    logic          ld_take;
    tag_e          tag;

    logic          if_gnt_o, lpm_gnt_o, if_valid_o, lpm_valid_o;
    logic [15:0]   if_data_o;
    logic [7:0]    lpm_data_o;
    logic          ld_ready_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [15:0]   mem_din_o;

`ifdef PROG_MEM_LOADER_EN
    assign ld_take = (state_q == RUN) && bus.ld_valid;
`else
    logic unused_ld;
    assign ld_take   = 1'b0;
    assign unused_ld = ^{bus.ld_valid, bus.ld_addr, bus.ld_data};
`endif

    assign grant_en = (state_q == RUN) && !rst;

    prog_mem_grant u_grant (
        .en      (grant_en),
        .ld_take (ld_take),
        .lpm_req (bus.lpm_req),
        .if_req  (bus.if_req),
        .starve  (starve_q),
        .tag     (tag)
    );

    always_comb begin
        state_d     = state_q;
        ld_count_d  = ld_count_q;
        ld_ready_o  = 1'b0;
        mem_we_o    = 1'b0;
        mem_din_o   = '0;
        mem_addr_o  = '0;

        if_gnt_o    = (tag == TAG_IF);
        lpm_gnt_o   = (tag == TAG_LPM);
        if (if_gnt_o) begin
            mem_addr_o = bus.if_addr;
        end else if (lpm_gnt_o) begin
            mem_addr_o = bus.lpm_addr[AW:1];
        end

        pend_d      = tag;
        starve_d    = lpm_gnt_o;
        lpm_lane_d  = lpm_gnt_o ? bus.lpm_addr[0] : lpm_lane_q;

        // Read data arrives one cycle after the grant; outputs hold between reads.
        if_valid_o  = !rst && (pend_q == TAG_IF);
        lpm_valid_o = !rst && (pend_q == TAG_LPM);
        if_data_o   = if_valid_o ? bus.mem_dout : if_data_q;
        if (lpm_valid_o) begin
            lpm_data_o = (lpm_lane_q == LANE_HI) ? bus.mem_dout[15:8] : bus.mem_dout[7:0];
        end else begin
            lpm_data_o = lpm_data_q;
        end

`ifdef PROG_MEM_LOADER_EN
        case (state_q)
            RUN: begin
                if (bus.ld_valid) begin
                    state_d    = LOAD;
                    ld_count_d = '0;
                end
            end
            LOAD: begin
                ld_ready_o = 1'b1;
                if (bus.ld_valid) begin
                    mem_we_o   = 1'b1;
                    mem_addr_o = bus.ld_addr;
                    mem_din_o  = bus.ld_data;
                    if (ld_count_q != CNT_MAX) begin
                        ld_count_d = ld_count_q + CNT_ONE;
                    end
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN:   state_d = RUN;
            default: state_d = RUN;
        endcase
`endif

        // A reset cycle must not leak a write or a stale read to the outside.
        if (rst) begin
            ld_ready_o  = 1'b0;
            mem_we_o    = 1'b0;
            mem_din_o   = '0;
            mem_addr_o  = '0;
            if_data_o   = '0;
            lpm_data_o  = '0;
        end

        if_data_d  = if_data_o;
        lpm_data_d = lpm_data_o;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            ld_count_q <= '0;
            starve_q   <= 1'b0;
            pend_q     <= TAG_NONE;
            lpm_lane_q <= LANE_LO;
            if_data_q  <= '0;
            lpm_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ld_count_q <= ld_count_d;
            starve_q   <= starve_d;
            pend_q     <= pend_d;
            lpm_lane_q <= lpm_lane_d;
            if_data_q  <= if_data_d;
            lpm_data_q <= lpm_data_d;
        end
    end

    assign bus.if_gnt    = if_gnt_o;
    assign bus.lpm_gnt   = lpm_gnt_o;
    assign bus.if_valid  = if_valid_o;
    assign bus.lpm_valid = lpm_valid_o;
    assign bus.if_data   = if_data_o;
    assign bus.lpm_data  = lpm_data_o;
    assign bus.ld_ready  = ld_ready_o;
    assign bus.cpu_hold  = (state_q != RUN);
    assign bus.ld_count  = ld_count_q;
    assign bus.mem_we    = mem_we_o;
    assign bus.mem_addr  = mem_addr_o;
    assign bus.mem_din   = mem_din_o;

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Self-checking bench for prog_mem_arbiter with a behavioural memory and request model.
// Loader scenarios run when PROG_MEM_LOADER_EN is defined, the disabled-loader scenario otherwise.
module tb_prog_mem_arbiter;
    import prog_mem_pkg::*;

    localparam int AW = PM_AW;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [15:0] mem [0:(1<<AW)-1];
    logic [15:0] model_if_data;
    logic [7:0]  model_lpm_data;

    always #5 clk = ~clk;

    prog_mem_if #(.AW(AW)) bus ();

    prog_mem_arbiter #(.AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Registered-read program memory behind the arbiter's port.
    always @(posedge clk) begin
        bus.mem_dout <= mem[bus.mem_addr];
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
    end

    task automatic drive(input logic r, input logic ir, input logic [AW-1:0] ia,
                         input logic lr, input logic [AW:0] la,
                         input logic lv, input logic [AW-1:0] lda, input logic [15:0] ldd);
        @(negedge clk);
        rst          = r;
        bus.if_req   = ir;
        bus.if_addr  = ia;
        bus.lpm_req  = lr;
        bus.lpm_addr = la;
        bus.ld_valid = lv;
        bus.ld_addr  = lda;
        bus.ld_data  = ldd;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 16'h0000);
    endtask

    task automatic test_reset();
        logic [127:0] obs;
        drive(1'b1, 1'b1, 14'h1234, 1'b1, 15'h0abc, 1'b1, 14'h0003, 16'hbeef);
        drive(1'b1, 1'b1, 14'h0222, 1'b1, 15'h0101, 1'b0, 14'h0000, 16'h0000);
        idle();
        obs = {bus.if_gnt, bus.if_valid, bus.if_data, bus.lpm_gnt, bus.lpm_valid, bus.lpm_data,
               bus.ld_ready, bus.cpu_hold, bus.ld_count, bus.mem_we, bus.mem_addr, bus.mem_din};
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %h required 0", obs);
        end
    endtask

    task automatic test_fetch();
        mem[14'h0010] = 16'hE221;
        drive(1'b0, 1'b1, 14'h0010, 1'b0, '0, 1'b0, '0, 16'h0000);
        checks++;
        if ({bus.if_gnt, bus.lpm_gnt} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL fetch_gnt: got %b required 10", {bus.if_gnt, bus.lpm_gnt});
        end
        checks++;
        if (bus.mem_addr !== 14'h0010) begin
            failures++;
            $display("[TB] FAIL fetch_addr: got %h required 0010", bus.mem_addr);
        end
        idle();
        checks++;
        if ({bus.if_valid, bus.lpm_valid} !== 2'b10 || bus.if_data !== 16'hE221) begin
            failures++;
            $display("[TB] FAIL fetch_data: valid %b data %h required 10 e221",
                     {bus.if_valid, bus.lpm_valid}, bus.if_data);
        end
        idle();
        checks++;
        if (bus.if_valid !== 1'b0 || bus.if_data !== 16'hE221) begin
            failures++;
            $display("[TB] FAIL fetch_hold: valid %b data %h required 0 e221", bus.if_valid, bus.if_data);
        end
    endtask

    task automatic test_lpm();
        mem[14'h0300] = 16'h9050;
        drive(1'b0, 1'b0, '0, 1'b1, 15'h0601, 1'b0, '0, 16'h0000);
        checks++;
        if ({bus.lpm_gnt, bus.if_gnt} !== 2'b10 || bus.mem_addr !== 14'h0300) begin
            failures++;
            $display("[TB] FAIL lpm_gnt_addr: gnt %b addr %h required 10 0300",
                     {bus.lpm_gnt, bus.if_gnt}, bus.mem_addr);
        end
        drive(1'b0, 1'b0, '0, 1'b1, 15'h0600, 1'b0, '0, 16'h0000);
        checks++;
        if (bus.lpm_valid !== 1'b1 || bus.lpm_data !== 8'h90) begin
            failures++;
            $display("[TB] FAIL lpm_high_byte: valid %b data %h required 1 90", bus.lpm_valid, bus.lpm_data);
        end
        idle();
        checks++;
        if (bus.lpm_valid !== 1'b1 || bus.lpm_data !== 8'h50) begin
            failures++;
            $display("[TB] FAIL lpm_low_byte: valid %b data %h required 1 50", bus.lpm_valid, bus.lpm_data);
        end
        idle();
        checks++;
        if (bus.lpm_valid !== 1'b0 || bus.lpm_data !== 8'h50) begin
            failures++;
            $display("[TB] FAIL lpm_hold: valid %b data %h required 0 50", bus.lpm_valid, bus.lpm_data);
        end
    endtask

    task automatic test_anti_starvation();
        logic [1:0] exp_gnt [4];
        exp_gnt[0] = 2'b01;
        exp_gnt[1] = 2'b10;
        exp_gnt[2] = 2'b01;
        exp_gnt[3] = 2'b10;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 14'h0040, 1'b1, 15'h0083, 1'b0, '0, 16'h0000);
            checks++;
            if ({bus.if_gnt, bus.lpm_gnt} !== exp_gnt[i]) begin
                failures++;
                $display("[TB] FAIL alt_gnt[%0d]: got %b required %b", i, {bus.if_gnt, bus.lpm_gnt}, exp_gnt[i]);
            end
            if (i > 0) begin
                checks++;
                if ({bus.if_valid, bus.lpm_valid} !== exp_gnt[i-1]) begin
                    failures++;
                    $display("[TB] FAIL alt_valid[%0d]: got %b required %b",
                             i, {bus.if_valid, bus.lpm_valid}, exp_gnt[i-1]);
                end
            end
        end
        idle();
        model_if_data  = mem[14'h0040];
        model_lpm_data = mem[14'h0041][15:8];
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_data !== model_if_data || bus.lpm_data !== model_lpm_data) begin
            failures++;
            $display("[TB] FAIL alt_data: if %h lpm %h required %h %h",
                     bus.if_data, bus.lpm_data, model_if_data, model_lpm_data);
        end
    endtask

    task automatic test_random_reads();
        logic          last_lpm = 1'b0;
        logic [1:0]    pend = 2'b00;
        logic [15:0]   pend_word = '0;
        logic          pend_hi = 1'b0;
        logic          ir, lr;
        logic [AW-1:0] ia, exp_addr;
        logic [AW:0]   la;
        logic [1:0]    g;
        for (int n = 0; n < 300; n++) begin
            ir = 1'($urandom_range(0, 1));
            lr = 1'($urandom_range(0, 1));
            ia = AW'($urandom);
            la = (AW+1)'($urandom);
            if (lr && !(last_lpm && ir)) g = 2'b01;
            else if (ir)                 g = 2'b10;
            else                         g = 2'b00;
            exp_addr = (g == 2'b10) ? ia : (g == 2'b01) ? la[AW:1] : '0;
            if (pend == 2'b10) model_if_data = pend_word;
            if (pend == 2'b01) model_lpm_data = pend_hi ? pend_word[15:8] : pend_word[7:0];
            drive(1'b0, ir, ia, lr, la, 1'b0, '0, 16'h0000);
            checks++;
            if ({bus.if_gnt, bus.lpm_gnt} !== g) begin
                failures++;
                $display("[TB] FAIL rnd_gnt[%0d]: got %b required %b", n, {bus.if_gnt, bus.lpm_gnt}, g);
            end
            checks++;
            if (bus.mem_addr !== exp_addr) begin
                failures++;
                $display("[TB] FAIL rnd_addr[%0d]: got %h required %h", n, bus.mem_addr, exp_addr);
            end
            checks++;
            if ({bus.if_valid, bus.lpm_valid} !== pend) begin
                failures++;
                $display("[TB] FAIL rnd_valid[%0d]: got %b required %b", n, {bus.if_valid, bus.lpm_valid}, pend);
            end
            checks++;
            if (bus.if_data !== model_if_data || bus.lpm_data !== model_lpm_data) begin
                failures++;
                $display("[TB] FAIL rnd_data[%0d]: if %h lpm %h required %h %h",
                         n, bus.if_data, bus.lpm_data, model_if_data, model_lpm_data);
            end
            pend      = g;
            pend_word = mem[exp_addr];
            pend_hi   = la[0];
            last_lpm  = (g == 2'b01);
        end
        idle();
    endtask

`ifdef PROG_MEM_LOADER_EN
    task automatic test_loader();
        logic [15:0] wdata [3];
        wdata[0] = 16'h1111;
        wdata[1] = 16'h2222;
        wdata[2] = 16'h3333;
        mem[14'h0010] = 16'hE221;
        drive(1'b0, 1'b1, 14'h0010, 1'b0, '0, 1'b0, '0, 16'h0000);
        drive(1'b0, 1'b1, 14'h0010, 1'b1, 15'h0011, 1'b1, 14'h0000, 16'h1111);
        checks++;
        if ({bus.if_gnt, bus.lpm_gnt, bus.ld_ready, bus.mem_we, bus.cpu_hold} !== 5'b0 ||
            bus.if_valid !== 1'b1 || bus.if_data !== 16'hE221) begin
            failures++;
            $display("[TB] FAIL ld_enter: gnt/rdy/we/hold %b valid %b data %h",
                     {bus.if_gnt, bus.lpm_gnt, bus.ld_ready, bus.mem_we, bus.cpu_hold},
                     bus.if_valid, bus.if_data);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 14'h0010, 1'b1, 15'h0011, 1'b1, AW'(i), wdata[i]);
            checks++;
            if ({bus.cpu_hold, bus.ld_ready, bus.mem_we, bus.if_gnt, bus.lpm_gnt} !== 5'b11100 ||
                bus.mem_addr !== AW'(i) || bus.mem_din !== wdata[i] || bus.ld_count !== (AW+1)'(i)) begin
                failures++;
                $display("[TB] FAIL ld_write[%0d]: flags %b addr %h din %h count %0d",
                         i, {bus.cpu_hold, bus.ld_ready, bus.mem_we, bus.if_gnt, bus.lpm_gnt},
                         bus.mem_addr, bus.mem_din, bus.ld_count);
            end
        end
        drive(1'b0, 1'b1, 14'h0010, 1'b0, '0, 1'b0, '0, 16'h0000);
        checks++;
        if ({bus.cpu_hold, bus.ld_ready, bus.mem_we, bus.if_gnt} !== 4'b1100 || bus.ld_count !== 15'd3) begin
            failures++;
            $display("[TB] FAIL ld_stop: flags %b count %0d required 1100 3",
                     {bus.cpu_hold, bus.ld_ready, bus.mem_we, bus.if_gnt}, bus.ld_count);
        end
        drive(1'b0, 1'b1, 14'h0010, 1'b0, '0, 1'b1, 14'h0005, 16'hdead);
        checks++;
        if ({bus.cpu_hold, bus.ld_ready, bus.mem_we, bus.if_gnt, bus.lpm_gnt} !== 5'b10000) begin
            failures++;
            $display("[TB] FAIL ld_drain: flags %b required 10000",
                     {bus.cpu_hold, bus.ld_ready, bus.mem_we, bus.if_gnt, bus.lpm_gnt});
        end
        drive(1'b0, 1'b1, 14'h0002, 1'b0, '0, 1'b0, '0, 16'h0000);
        checks++;
        if ({bus.cpu_hold, bus.if_gnt} !== 2'b01 || bus.mem_addr !== 14'h0002 || bus.ld_count !== 15'd3) begin
            failures++;
            $display("[TB] FAIL ld_back_to_run: hold/gnt %b addr %h count %0d",
                     {bus.cpu_hold, bus.if_gnt}, bus.mem_addr, bus.ld_count);
        end
        idle();
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_data !== 16'h3333 ||
            mem[0] !== 16'h1111 || mem[1] !== 16'h2222 || mem[5] === 16'hdead) begin
            failures++;
            $display("[TB] FAIL ld_contents: data %h mem0 %h mem1 %h mem5 %h",
                     bus.if_data, mem[0], mem[1], mem[5]);
        end
    endtask

    task automatic test_reset_in_load();
        logic [127:0] obs;
        mem[14'h0021] = 16'h5A5A;
        mem[5]        = 16'h0000;
        idle();
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 14'h0020, 16'hAAAA);
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 14'h0020, 16'hAAAA);
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 14'h0021, 16'hBBBB);
        checks++;
        if (bus.mem_we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_load_we: got %b required 0", bus.mem_we);
        end
        idle();
        obs = {bus.if_gnt, bus.if_valid, bus.if_data, bus.lpm_gnt, bus.lpm_valid, bus.lpm_data,
               bus.ld_ready, bus.cpu_hold, bus.ld_count, bus.mem_we, bus.mem_addr, bus.mem_din};
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("[TB] FAIL rst_load_outputs: got %h required 0", obs);
        end
        idle();
        checks++;
        if (mem[14'h0021] !== 16'h5A5A || mem[14'h0020] !== 16'hAAAA) begin
            failures++;
            $display("[TB] FAIL rst_load_mem: mem20 %h mem21 %h required aaaa 5a5a",
                     mem[14'h0020], mem[14'h0021]);
        end
    endtask
`else
    task automatic test_loader_disabled();
        logic [AW-1:0] ia, prev_ia;
        prev_ia = '0;
        for (int i = 0; i < 5; i++) begin
            ia = AW'($urandom);
            drive(1'b0, 1'b1, ia, 1'b0, '0, 1'b1, AW'($urandom), 16'($urandom));
            checks++;
            if ({bus.mem_we, bus.cpu_hold, bus.ld_ready} !== 3'b000 || bus.ld_count !== '0 ||
                bus.mem_din !== 16'h0000) begin
                failures++;
                $display("[TB] FAIL nold_idle[%0d]: we/hold/rdy %b count %0d din %h", i,
                         {bus.mem_we, bus.cpu_hold, bus.ld_ready}, bus.ld_count, bus.mem_din);
            end
            checks++;
            if (bus.if_gnt !== 1'b1 || bus.mem_addr !== ia) begin
                failures++;
                $display("[TB] FAIL nold_fetch[%0d]: gnt %b addr %h required 1 %h", i, bus.if_gnt, bus.mem_addr, ia);
            end
            if (i > 0) begin
                checks++;
                if (bus.if_valid !== 1'b1 || bus.if_data !== mem[prev_ia]) begin
                    failures++;
                    $display("[TB] FAIL nold_data[%0d]: valid %b data %h required 1 %h",
                             i, bus.if_valid, bus.if_data, mem[prev_ia]);
                end
            end
            prev_ia = ia;
        end
        idle();
    endtask
`endif

    initial begin
        for (int i = 0; i < (1<<AW); i++) mem[i] = 16'($urandom);
        model_if_data  = '0;
        model_lpm_data = '0;
        rst = 1'b1;
        bus.if_req = 1'b0;  bus.if_addr = '0;
        bus.lpm_req = 1'b0; bus.lpm_addr = '0;
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;

        test_reset();
        test_fetch();
        test_lpm();
        test_anti_starvation();
        test_random_reads();
`ifdef PROG_MEM_LOADER_EN
        test_loader();
        test_reset_in_load();
`else
        test_loader_disabled();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
